// File: rtl/mips_fetch_pkg.sv
// Shared types for the MIPS fetch stage: FSM state encoding and queue entry layout.
// No logic; types and constants only.
// Imported by fetch_queue and instruction_fetch_unit.
package mips_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, instr} entries with flush.
// Latency: a push is visible at the head on the cycle after the write edge (no bypass).
// Backpressure: no full flag; the producer must not push when count_o == DEPTH. Pop on empty is ignored.
module fetch_queue
  import mips_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  fetch_entry_t             push_entry_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            push_ok;
  logic            pop_ok;

  // Flush dominates: anything pushed or popped alongside a flush is discarded.
  assign push_ok = push_i && !flush_i;
  assign pop_ok  = pop_i && !flush_i && (count_q != '0);

  // Entry storage; contents past the valid window are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: owns fetch PC, issues single outstanding imem reads, queues {pc, instr} for decode.
// Latency: ack at edge n gives instr_valid in cycle n+1; zero-wait memory sustains one instr per cycle.
// Backpressure: stops issuing when the queue is full; instr_ready low holds the head; redirect flushes.
module instruction_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int             CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  fetch_state_t   state_q, state_d;
  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic [31:0]    addr_q, addr_d;

  logic           push;
  logic           pop;
  fetch_entry_t   push_entry;
  fetch_entry_t   head;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_post;
  logic [31:0]    redirect_pc_al;
  logic [31:0]    fetch_pc_inc;

  assign redirect_pc_al = redirect_pc & 32'hFFFF_FFFC;
  assign fetch_pc_inc   = fetch_pc_q + 32'd4;

  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready;
  assign instr       = instr_valid ? head.instr : 32'h0;
  assign instr_pc    = instr_valid ? head.pc    : 32'h0;

  // Occupancy after this cycle's push and pop, used to decide whether to keep issuing.
  assign count_post = count + CW'(1) - CW'(pop);

  assign imem_req  = (state_q != IDLE);
  assign imem_addr = addr_q;

  // Fetch FSM: issue decision, transfer handling and redirect tracking.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    push       = 1'b0;
    push_entry = '{pc: addr_q, instr: imem_rdata};
    case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          // Queue is flushed this cycle, so there is room to start at the new PC.
          fetch_pc_d = redirect_pc_al;
          addr_d     = redirect_pc_al;
          state_d    = BUSY;
        end else if (count < DEPTH_C) begin
          addr_d  = fetch_pc_q;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc_al;
          // Without an ack the request stays live with its old address until memory answers.
          state_d    = imem_ack ? IDLE : DISCARD;
        end else if (imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_inc;
          if (count_post < DEPTH_C) begin
            addr_d = fetch_pc_inc;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DISCARD: begin
        if (redirect_valid) fetch_pc_d = redirect_pc_al;
        if (imem_ack)       state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, fetch PC and live request address registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .flush_i      (redirect_valid),
    .head_o       (head),
    .count_o      (count)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: throughput, backpressure, redirect, wrap and async reset.
module tb_instruction_fetch_unit;

  localparam logic [31:0] K = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Memory returns its address scrambled by a constant, so instr and pc differ.
  assign imem_rdata = imem_addr ^ K;

  instruction_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    #1 reset = 1'b1;
    tick;
    tick;
    chk("rst_req",   {31'b0, imem_req},    32'd0);
    chk("rst_addr",  imem_addr,            32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr,                32'h0);
    chk("rst_pc",    instr_pc,             32'h0);

    // Zero-wait streaming
    reset = 1'b0; imem_ack = 1'b1; instr_ready = 1'b1;
    tick;
    chk("s_req1",   {31'b0, imem_req},    32'd1);
    chk("s_addr1",  imem_addr,            32'h0);
    chk("s_valid1", {31'b0, instr_valid}, 32'd0);
    tick;
    chk("s_valid2", {31'b0, instr_valid}, 32'd1);
    chk("s_pc0",    instr_pc,             32'h0);
    chk("s_in0",    instr,                K);
    for (int k = 1; k <= 5; k++) begin
      tick;
      chk("s_pc",    instr_pc,             32'(4 * k));
      chk("s_in",    instr,                32'(4 * k) ^ K);
      chk("s_valid", {31'b0, instr_valid}, 32'd1);
    end

    // Backpressure: fill to DEPTH, then drain in order
    reset = 1'b1;
    tick;
    reset = 1'b0; imem_ack = 1'b1; instr_ready = 1'b0;
    tick;
    chk("f_req1", {31'b0, imem_req}, 32'd1);
    tick; tick; tick; tick;
    chk("f_req_full", {31'b0, imem_req},    32'd0);
    chk("f_valid",    {31'b0, instr_valid}, 32'd1);
    chk("f_pc0",      instr_pc,             32'h0);
    chk("f_in0",      instr,                K);
    tick;
    chk("f_req_hold", {31'b0, imem_req}, 32'd0);
    instr_ready = 1'b1;
    tick;
    chk("d_pc4",   instr_pc,          32'h4);
    chk("d_req0",  {31'b0, imem_req}, 32'd0);
    tick;
    chk("d_pc8",   instr_pc,          32'h8);
    chk("d_req1",  {31'b0, imem_req}, 32'd1);
    chk("d_addr",  imem_addr,         32'h10);
    tick;
    chk("d_pc12",  instr_pc,          32'hC);
    tick;
    chk("d_pc16",  instr_pc,          32'h10);

    // Delayed ack with redirect: stale request completes and is dropped
    reset = 1'b1;
    tick;
    reset = 1'b0; imem_ack = 1'b0; instr_ready = 1'b1;
    tick;
    chk("r_req", {31'b0, imem_req}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick;
    redirect_valid = 1'b0;
    chk("r_stale_req",  {31'b0, imem_req},    32'd1);
    chk("r_stale_addr", imem_addr,            32'h0);
    chk("r_valid0",     {31'b0, instr_valid}, 32'd0);
    tick;
    chk("r_stale_addr2", imem_addr, 32'h0);
    imem_ack = 1'b1;
    tick;
    chk("r_drop_req",   {31'b0, imem_req},    32'd0);
    chk("r_drop_valid", {31'b0, instr_valid}, 32'd0);
    tick;
    chk("r_new_req",  {31'b0, imem_req}, 32'd1);
    chk("r_new_addr", imem_addr,         32'h100);
    tick;
    chk("r_new_valid", {31'b0, instr_valid}, 32'd1);
    chk("r_new_pc",    instr_pc,             32'h100);
    chk("r_new_in",    instr,                32'h100 ^ K);

    // Redirect to unaligned 0x203 together with ack and pop
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
    tick;
    redirect_valid = 1'b0;
    chk("x_flush_valid", {31'b0, instr_valid}, 32'd0);
    chk("x_req_idle",    {31'b0, imem_req},    32'd0);
    tick;
    chk("x_req",   {31'b0, imem_req},    32'd1);
    chk("x_addr",  imem_addr,            32'h200);
    chk("x_valid", {31'b0, instr_valid}, 32'd0);
    tick;
    chk("x_pc", instr_pc, 32'h200);

    // Address wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick;
    redirect_valid = 1'b0;
    chk("w_valid0", {31'b0, instr_valid}, 32'd0);
    tick;
    chk("w_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick;
    chk("w_pc_top",    instr_pc,  32'hFFFF_FFFC);
    chk("w_in_top",    instr,     32'hFFFF_FFFC ^ K);
    chk("w_addr_wrap", imem_addr, 32'h0);
    tick;
    chk("w_pc_wrap", instr_pc, 32'h0);
    chk("w_in_wrap", instr,    K);

    // Async reset with three entries queued
    instr_ready = 1'b0;
    tick;
    tick;
    chk("a_valid", {31'b0, instr_valid}, 32'd1);
    chk("a_pc",    instr_pc,             32'h0);
    chk("a_req",   {31'b0, imem_req},    32'd1);
    chk("a_addr",  imem_addr,            32'hC);
    imem_ack = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("a_rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("a_rst_req",   {31'b0, imem_req},    32'd0);
    chk("a_rst_addr",  imem_addr,            32'h0);
    chk("a_rst_instr", instr,                32'h0);
    #1 reset = 1'b0;
    imem_ack = 1'b1; instr_ready = 1'b1;
    tick;
    chk("a_re_req",   {31'b0, imem_req},    32'd1);
    chk("a_re_addr",  imem_addr,            32'h0);
    chk("a_re_valid", {31'b0, instr_valid}, 32'd0);
    tick;
    chk("a_re_pc", instr_pc, 32'h0);
    chk("a_re_in", instr,    K);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
